// File: rtl/conv_flush_seq.sv
// conv_flush_seq: forwards one W x H frame with position tags, then injects FLUSH_ROWS x W zero pixels.
// Optional framing checks: define CONV_FLUSH_SEQ_ERR_CHK_EN.
`timescale 1ns/1ps

package conv_pkg;
  typedef logic [7:0] pixel_t;
endpackage

module conv_flush_seq #(
  parameter int W          = 1920,
  parameter int H          = 1080,
  parameter int FLUSH_ROWS = 2,
  localparam int RW        = $clog2(H + FLUSH_ROWS),
  localparam int CW        = $clog2(W)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             s_tvalid_i,
  input  conv_pkg::pixel_t s_tdata_i,
  input  logic             s_tuser_i,
  input  logic             s_tlast_i,
  output logic             s_tready_o,
  input  logic             m_tready_i,
  output logic             m_tvalid_o,
  output conv_pkg::pixel_t m_tdata_o,
  output logic             m_tuser_o,
  output logic             m_tlast_o,
  output logic             m_tflush_o,
  output logic [RW-1:0]    m_row_o,
  output logic [CW-1:0]    m_col_o,
  output logic             busy_o,
  output logic             err_o,
  input  logic             err_clr_i
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_FLUSH = 2'd2
  } state_t;

  typedef struct packed {
    conv_pkg::pixel_t data;
    logic             user;
    logic             last;
    logic             flush;
    logic [RW-1:0]    row;
    logic [CW-1:0]    col;
  } beat_t;

  localparam logic [CW-1:0] COL_LAST       = CW'(W - 1);
  localparam logic [RW-1:0] ROW_LAST_PIX   = RW'(H - 1);
  localparam logic [RW-1:0] ROW_LAST_FLUSH = RW'(H + FLUSH_ROWS - 1);

  function automatic beat_t make_beat(input conv_pkg::pixel_t d, input logic u, input logic l,
                                      input logic f, input logic [RW-1:0] r, input logic [CW-1:0] c);
    beat_t b;
    b.data  = d;
    b.user  = u;
    b.last  = l;
    b.flush = f;
    b.row   = r;
    b.col   = c;
    return b;
  endfunction

  state_t        r_state;
  logic [RW-1:0] r_row;
  logic [CW-1:0] r_col;
  logic          r_m_tvalid;
  beat_t         r_beat;

  logic w_ld;
  logic w_acc;
  logic w_col_last;
  logic w_sof_abort;
  logic w_err_set;

  assign w_ld       = !r_m_tvalid || m_tready_i;
  assign s_tready_o = (r_state != ST_FLUSH) && w_ld;
  assign w_acc      = s_tvalid_i && s_tready_o;
  assign w_col_last = (r_col == COL_LAST);

  // framing violations detected on the beat being accepted this cycle
  always_comb begin
    w_sof_abort = 1'b0;
    w_err_set   = 1'b0;
`ifdef CONV_FLUSH_SEQ_ERR_CHK_EN
    if (w_acc && (r_state == ST_PASS)) begin
      w_sof_abort = s_tuser_i;
      w_err_set   = s_tuser_i || (s_tlast_i != w_col_last);
    end else if (w_acc && (r_state == ST_IDLE)) begin
      w_err_set   = !s_tuser_i;
    end else begin
      w_err_set   = 1'b0;
    end
`endif
  end

`ifdef CONV_FLUSH_SEQ_ERR_CHK_EN
  logic r_err;

  // sticky error flag; a new violation beats a simultaneous clear
  always_ff @(posedge clk) begin
    if (srst) begin
      r_err <= 1'b0;
    end else if (w_err_set) begin
      r_err <= 1'b1;
    end else if (err_clr_i) begin
      r_err <= 1'b0;
    end
  end

  assign err_o = r_err;
`else
  logic w_unused;
  assign w_unused = ^{err_clr_i, s_tlast_i, w_err_set};
  assign err_o    = 1'b0;
`endif

  // frame sequencer and output register; nothing moves while the output is stalled
  always_ff @(posedge clk) begin
    if (srst) begin
      r_state    <= ST_IDLE;
      r_row      <= RW'(0);
      r_col      <= CW'(0);
      r_m_tvalid <= 1'b0;
      r_beat     <= make_beat(8'd0, 1'b0, 1'b0, 1'b0, RW'(0), CW'(0));
    end else if (w_ld) begin
      r_m_tvalid <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_acc && s_tuser_i) begin
            r_m_tvalid <= 1'b1;
            r_beat     <= make_beat(s_tdata_i, 1'b1, 1'b0, 1'b0, RW'(0), CW'(0));
            r_row      <= RW'(0);
            r_col      <= CW'(1);
            r_state    <= ST_PASS;
          end
        end
        ST_PASS: begin
          if (w_acc && w_sof_abort) begin
            // restart: this beat becomes pixel (0,0) of a new frame
            r_m_tvalid <= 1'b1;
            r_beat     <= make_beat(s_tdata_i, 1'b1, 1'b0, 1'b0, RW'(0), CW'(0));
            r_row      <= RW'(0);
            r_col      <= CW'(1);
          end else if (w_acc) begin
            r_m_tvalid <= 1'b1;
            r_beat     <= make_beat(s_tdata_i, 1'b0, w_col_last, 1'b0, r_row, r_col);
            if (w_col_last) begin
              r_col <= CW'(0);
              r_row <= r_row + RW'(1);
              if (r_row == ROW_LAST_PIX) begin
                r_state <= ST_FLUSH;
              end
            end else begin
              r_col <= r_col + CW'(1);
            end
          end
        end
        ST_FLUSH: begin
          r_m_tvalid <= 1'b1;
          r_beat     <= make_beat(8'd0, 1'b0, w_col_last, 1'b1, r_row, r_col);
          if (w_col_last) begin
            r_col <= CW'(0);
            if (r_row == ROW_LAST_FLUSH) begin
              r_row   <= RW'(0);
              r_state <= ST_IDLE;
            end else begin
              r_row <= r_row + RW'(1);
            end
          end else begin
            r_col <= r_col + CW'(1);
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_row   <= RW'(0);
          r_col   <= CW'(0);
        end
      endcase
    end
  end

  assign m_tvalid_o = r_m_tvalid;
  assign m_tdata_o  = r_beat.data;
  assign m_tuser_o  = r_beat.user;
  assign m_tlast_o  = r_beat.last;
  assign m_tflush_o = r_beat.flush;
  assign m_row_o    = r_beat.row;
  assign m_col_o    = r_beat.col;
  assign busy_o     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_conv_flush_seq.sv
// Scoreboard bench for conv_flush_seq (W=4, H=3, FLUSH_ROWS=2); follows CONV_FLUSH_SEQ_ERR_CHK_EN if defined.
`timescale 1ns/1ps

module tb_conv_flush_seq;
  localparam int W  = 4;
  localparam int H  = 3;
  localparam int FR = 2;
  localparam int RW = $clog2(H + FR);
  localparam int CW = $clog2(W);
`ifdef CONV_FLUSH_SEQ_ERR_CHK_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             srst;
  logic             s_tvalid_i;
  conv_pkg::pixel_t s_tdata_i;
  logic             s_tuser_i;
  logic             s_tlast_i;
  logic             s_tready_o;
  logic             m_tready_i;
  logic             m_tvalid_o;
  conv_pkg::pixel_t m_tdata_o;
  logic             m_tuser_o;
  logic             m_tlast_o;
  logic             m_tflush_o;
  logic [RW-1:0]    m_row_o;
  logic [CW-1:0]    m_col_o;
  logic             busy_o;
  logic             err_o;
  logic             err_clr_i;

  always #5 clk = ~clk;

  conv_flush_seq #(.W(W), .H(H), .FLUSH_ROWS(FR)) dut (
    .clk(clk), .srst(srst),
    .s_tvalid_i(s_tvalid_i), .s_tdata_i(s_tdata_i), .s_tuser_i(s_tuser_i),
    .s_tlast_i(s_tlast_i), .s_tready_o(s_tready_o),
    .m_tready_i(m_tready_i), .m_tvalid_o(m_tvalid_o), .m_tdata_o(m_tdata_o),
    .m_tuser_o(m_tuser_o), .m_tlast_o(m_tlast_o), .m_tflush_o(m_tflush_o),
    .m_row_o(m_row_o), .m_col_o(m_col_o), .busy_o(busy_o), .err_o(err_o),
    .err_clr_i(err_clr_i)
  );

  typedef struct packed {
    logic [7:0]    data;
    logic          user;
    logic          last;
    logic          flush;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // reference model state: position of the next pixel as a linear index within the frame
  bit   mon_en   = 1'b0;
  bit   in_frame = 1'b0;
  int   pix_idx  = 0;
  bit   err_exp  = 1'b0;
  bit   hold_chk = 1'b0;
  exp_t snap;
  exp_t cur;
  exp_t got;
  int   rdy_mode = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic exp_t mk(input logic [7:0] d, input bit u, input bit l, input bit f,
                              input int r, input int c);
    exp_t e;
    e.data  = d;
    e.user  = u;
    e.last  = l;
    e.flush = f;
    e.row   = RW'(r);
    e.col   = CW'(c);
    return e;
  endfunction

  // apply one accepted input beat to the model; returns whether it is a framing error
  function automatic bit model_accept(input logic [7:0] d, input logic u, input logic l);
    bit es = 1'b0;
    int r;
    int c;
    if (!in_frame) begin
      if (u) begin
        exp_q.push_back(mk(d, 1'b1, 1'b0, 1'b0, 0, 0));
        in_frame = 1'b1;
        pix_idx  = 1;
      end else begin
        es = ERR_EN;
      end
    end else if (ERR_EN && u) begin
      exp_q.push_back(mk(d, 1'b1, 1'b0, 1'b0, 0, 0));
      pix_idx = 1;
      es      = 1'b1;
    end else begin
      r = pix_idx / W;
      c = pix_idx % W;
      exp_q.push_back(mk(d, 1'b0, c == W - 1, 1'b0, r, c));
      if (ERR_EN && (l != (c == W - 1))) es = 1'b1;
      pix_idx++;
      if (pix_idx == W * H) begin
        for (int k = 0; k < W * FR; k++)
          exp_q.push_back(mk(8'd0, 1'b0, (k % W) == W - 1, 1'b1, H + k / W, k % W));
        in_frame = 1'b0;
        pix_idx  = 0;
      end
    end
    return es;
  endfunction

  // monitor: sample at negedge, predict the coming posedge
  always @(negedge clk) begin
    if (mon_en) begin
      cur = {m_tdata_o, m_tuser_o, m_tlast_o, m_tflush_o, m_row_o, m_col_o};
      if (hold_chk) begin
        chk("stall_hold", 32'(cur), 32'(snap));
        chk("stall_valid", 32'(m_tvalid_o), 32'd1);
      end
      chk("err_o", 32'(err_o), 32'(err_exp));
      if (srst) begin
        exp_q.delete();
        in_frame = 1'b0;
        pix_idx  = 0;
        err_exp  = 1'b0;
        hold_chk = 1'b0;
      end else begin
        if (m_tvalid_o && m_tready_i) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_beat: got %0h expected none at %0t", cur, $time);
          end else begin
            got = exp_q.pop_front();
            chk("beat", 32'(cur), 32'(got));
          end
        end
        hold_chk = m_tvalid_o && !m_tready_i;
        snap     = cur;
        if (s_tvalid_i && s_tready_o) begin
          if (model_accept(s_tdata_i, s_tuser_i, s_tlast_i)) err_exp = 1'b1;
          else if (err_clr_i) err_exp = 1'b0;
        end else if (err_clr_i) begin
          err_exp = 1'b0;
        end
      end
    end
  end

  // downstream ready pattern: 0 always ready, 1 toggling, 2 random
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      1:       m_tready_i = ~m_tready_i;
      2:       m_tready_i = 1'($urandom_range(0, 1));
      default: m_tready_i = 1'b1;
    endcase
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] d, input logic u, input logic l, input int gap);
    int n = 0;
    repeat (gap) tick();
    s_tvalid_i = 1'b1;
    s_tdata_i  = d;
    s_tuser_i  = u;
    s_tlast_i  = l;
    forever begin
      @(negedge clk);
      if (s_tready_o) break;
      n++;
      if (n > 200) begin
        checks++;
        errors++;
        $display("FAIL send_timeout: got no ready expected ready within 200 cycles");
        break;
      end
    end
    tick();
    s_tvalid_i = 1'b0;
  endtask

  task automatic send_frame(input bit rnd, input int max_gap);
    for (int i = 0; i < W * H; i++)
      send(rnd ? 8'($urandom) : 8'(i + 1), i == 0, (i % W) == W - 1,
           (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0);
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy_o) && n < 500) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", 32'(n < 500), 32'd1);
    tick();
  endtask

  task automatic pulse_clr();
    err_clr_i = 1'b1;
    tick();
    err_clr_i = 1'b0;
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    srst       = 1'b1;
    s_tvalid_i = 1'b0;
    s_tdata_i  = 8'd0;
    s_tuser_i  = 1'b0;
    s_tlast_i  = 1'b0;
    err_clr_i  = 1'b0;
    m_tready_i = 1'b1;
    repeat (3) tick();
    srst   = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("rst_tvalid", 32'(m_tvalid_o), 32'd0);
    chk("rst_beat", 32'({m_tdata_o, m_tuser_o, m_tlast_o, m_tflush_o, m_row_o, m_col_o}), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_tready", 32'(s_tready_o), 32'd1);
    tick();

    // clean frame, always ready: 8 back-pressured flush cycles then idle
    send_frame(1'b0, 0);
    n = 0;
    @(negedge clk);
    while (!s_tready_o && n < 50) begin
      n++;
      @(negedge clk);
    end
    chk("flush_backpressure_cycles", 32'(n), 32'd8);
    chk("idle_after_flush", 32'(busy_o), 32'd0);
    drain();

    // toggling downstream ready
    rdy_mode = 1;
    send_frame(1'b0, 0);
    drain();
    rdy_mode = 0;

    // three non-SOF beats in idle are dropped, then a clean frame
    for (int i = 0; i < 3; i++) send(8'($urandom), 1'b0, 1'b0, 0);
    send_frame(1'b0, 0);
    drain();
    pulse_clr();

    // early tlast at (0,2)
    for (int i = 0; i < W * H; i++)
      send(8'(i + 1), i == 0, ((i % W) == W - 1) || (i == 2), 0);
    pulse_clr();
    drain();

    // SOF on pixel (1,2): abort and restart
    for (int i = 0; i < 6; i++) send(8'(i + 1), i == 0, (i % W) == W - 1, 0);
    send(8'h70, 1'b1, 1'b0, 0);
    for (int i = 1; i < W * H; i++) send(8'(8'h70 + i), 1'b0, (i % W) == W - 1, 0);
    drain();
    pulse_clr();

    // reset on the third flush cycle
    send_frame(1'b1, 0);
    tick();
    tick();
    srst = 1'b1;
    tick();
    srst = 1'b0;
    @(negedge clk);
    chk("srst_tvalid", 32'(m_tvalid_o), 32'd0);
    chk("srst_busy", 32'(busy_o), 32'd0);
    chk("srst_tready", 32'(s_tready_o), 32'd1);
    chk("srst_pos", 32'({m_row_o, m_col_o}), 32'd0);
    tick();
    send_frame(1'b1, 0);
    drain();

    // randomized frames with gaps and random ready
    rdy_mode = 2;
    for (int f = 0; f < 4; f++) begin
      if ($urandom_range(0, 1) == 1) send(8'($urandom), 1'b0, 1'b0, 0);
      send_frame(1'b1, 2);
      drain();
      pulse_clr();
    end
    rdy_mode = 0;
    repeat (3) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/conv_flush_seq.md
# conv_flush_seq

Frame-level sequencer placed ahead of `conv` on the pixel stream. It forwards one frame of `W`×`H` pixels, tags every output beat with its row/column position and regenerated start-of-frame (SOF) / end-of-line (EOL) flags, then injects `FLUSH_ROWS`×`W` zero pixels to drain the 5×5 kernel line buffers. It also polices input framing and raises a sticky error on malformed frames.

## Interface
Parameters:
- `W`, default 1920: image width in pixels. Must be ≥ 2.
- `H`, default 1080: image height in lines. Must be ≥ 1.
- `FLUSH_ROWS`, default 2: number of drain lines injected after each frame. Must be ≥ 1.

Ports:
- `clk`  in  1  clock
- `srst`  in  1  synchronous active-high reset. One clock; reset is synchronous and active-high.
- `s_tvalid_i`  in  1  input beat valid
- `s_tdata_i`  in  `conv_pkg::pixel_t`  input pixel
- `s_tuser_i`  in  1  input SOF
- `s_tlast_i`  in  1  input EOL
- `s_tready_o`  out  1  input ready
- `m_tready_i`  in  1  downstream ready
- `m_tvalid_o`  out  1  output beat valid
- `m_tdata_o`  out  `conv_pkg::pixel_t`  output pixel; 0 on flush beats
- `m_tuser_o`  out  1  asserted on beat (0,0) only
- `m_tlast_o`  out  1  asserted when col == `W-1`, on real and flush beats
- `m_tflush_o`  out  1  beat is an injected drain pixel
- `m_row_o`  out  `$clog2(H+FLUSH_ROWS)`  row of the beat
- `m_col_o`  out  `$clog2(W)`  column of the beat
- `busy_o`  out  1  state ≠ IDLE
- `err_o`  out  1  sticky framing error
- `err_clr_i`  in  1  clears `err_o`

## Operation
- Output register stage. It loads when `ld = !m_tvalid_o || m_tready_i`.
- `s_tready_o = (state != FLUSH) && ld`. This is combinational from `m_tready_i`.
- Counters `row_q`/`col_q` hold the position of the next beat. `col_q` wraps at `W-1` and increments `row_q`.
- States:
  - IDLE:
    - Accepted beat with `s_tuser_i=0`: dropped, not forwarded; sets `err_o`.
    - Accepted beat with `s_tuser_i=1`: forwarded as (0,0) with `m_tuser_o=1`; counters go to (0,1); next state PASS.
  - PASS:
    - Each accepted beat is forwarded at (`row_q`,`col_q`), then counters advance.
    - The counters are authoritative for `m_tlast_o`.
    - Accepting (`H-1`,`W-1`) moves to FLUSH with counters at (`H`,0).
  - FLUSH:
    - On each `ld`, emits a beat with `m_tdata_o=0`, `m_tflush_o=1` at (`row_q`,`col_q`).
    - After emitting (`H+FLUSH_ROWS-1`,`W-1`), moves to IDLE with counters at (0,0).
    - Input is back-pressured for the whole state.
- Framing checks in PASS (with `CONV_FLUSH_SEQ_ERR_CHK_EN`):
  - `s_tlast_i` ≠ (`col_q==W-1`): sets `err_o`. The beat is still forwarded with the counter-derived `m_tlast_o`.
  - `s_tuser_i=1` on an accepted beat: sets `err_o` and aborts the current frame. The beat is forwarded as (0,0) with `m_tuser_o=1`, counters go to (0,1), and the state stays PASS. No flush is issued for the aborted frame.
- `err_o` set and `err_clr_i` in the same cycle: set wins.

## Timing
- Reset values:
  - state IDLE, counters 0.
  - `m_tvalid_o=0`, `m_tdata_o=0`, `m_tuser_o=0`, `m_tlast_o=0`, `m_tflush_o=0`, `m_row_o=0`, `m_col_o=0`.
  - `err_o=0`, `busy_o=0`.
  - `s_tready_o=1` in the first cycle after reset.
- Latency:
  - Input beat accepted at cycle N appears on the output at N+1.
  - Full throughput of 1 beat/cycle when `m_tready_i=1`.
- PASS→FLUSH:
  - The first flush beat loads in the cycle after the last frame pixel is accepted. No bubble when unstalled.
  - A frame costs `W·H` input cycles plus `W·FLUSH_ROWS` flush cycles.
- Stall: while `m_tvalid_o && !m_tready_i`, all `m_*` outputs are held stable.
- `srst` mid-frame or mid-flush: next cycle all state is at reset values. The in-flight output beat is discarded.

## Configuration
- `CONV_FLUSH_SEQ_ERR_CHK_EN` defined:
  - PASS-state `s_tlast_i`/`s_tuser_i` checks and mid-frame SOF abort are active.
  - `err_o` is set by those checks and by IDLE non-SOF drops.
- Not defined:
  - `s_tlast_i` is ignored, and `s_tuser_i` is ignored in PASS.
  - IDLE still drops non-SOF beats silently.
  - `err_o` is tied to 0; `err_clr_i` is unused.

## Test plan
(`W=4`, `H=3`, `FLUSH_ROWS=2`, checks enabled unless noted.)
1. Clean 12-pixel frame with data 1..12, `m_tready_i=1`:
   - 12 beats out at 1-cycle latency; `m_tuser_o` on beat 1 only; `m_tlast_o` on beats 4, 8, 12.
   - Then 8 zero beats with `m_tflush_o=1` at rows 3–4; `s_tready_o=0` for 8 cycles.
   - Then IDLE with `busy_o=0`; `err_o` stays 0.
2. Same frame with `m_tready_i` toggling 1,0,1,0:
   - All 20 beats delivered in order with no loss or duplication.
   - `m_*` outputs stable during every stall cycle.
3. Three `s_tuser_i=0` beats in IDLE, then a clean frame:
   - The three beats are accepted and dropped; `err_o=1` on the cycle after the first drop.
   - The frame is output exactly as in scenario 1.
4. `s_tlast_i=1` at col 2 of row 0:
   - `err_o` rises; `m_tlast_o` is asserted only at col 3.
   - Pulsing `err_clr_i` clears `err_o` the next cycle.
   - The same scenario without the macro gives `err_o=0` throughout.
5. `s_tuser_i=1` on the beat at (1,2):
   - `err_o=1`; that beat is output with `m_row_o=0`, `m_col_o=0`, `m_tuser_o=1`.
   - No flush beats are emitted before the restarted frame completes; that frame then flushes normally.
6. `srst` asserted on the 3rd flush cycle:
   - Next cycle: `m_tvalid_o=0`, `busy_o=0`, `s_tready_o=1`, counters 0.
   - A following SOF starts a fresh frame at (0,0).
